// File: rtl/pwm_servo_frame_gen_8ch.sv
// rtl/pwm_servo_frame_gen_8ch.sv - eight-channel frame-aligned servo PWM generator with clamp and slew limiting
module pwm_servo_frame_gen_8ch #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int FRAME_US    = 20000,
    parameter int MIN_US      = 500,
    parameter int MAX_US      = 2500,
    parameter int NEUTRAL_US  = 1500,
    parameter int SLEW_US     = 0
) (
    input  logic         ACLK,
    input  logic         ARESET,
    input  logic [127:0] pulse_width_flat,
    input  logic [7:0]   ch_enable,
    output logic [7:0]   pwm_out,
    output logic         frame_start,
    output logic [127:0] active_width_flat
);

    localparam int              DIV        = CLK_FREQ_HZ / 1000000;
    localparam int              PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST   = PW'(DIV - 1);
    localparam logic [14:0]     FRAME_LAST = 15'(FRAME_US - 1);
    localparam logic [15:0]     MIN_W      = 16'(MIN_US);
    localparam logic [15:0]     MAX_W      = 16'(MAX_US);
    localparam logic [15:0]     NEUTRAL_W  = 16'(NEUTRAL_US);
    localparam logic [15:0]     SLEW_W     = 16'(SLEW_US);
    localparam logic [16:0]     SLEW_D     = 17'(SLEW_US);

    logic [PW-1:0] pre_cnt;
    logic [14:0]   us_cnt;
    logic          tick;
    logic          boundary;
    logic [7:0]    en_active;
    logic [15:0]   active      [8];
    logic [15:0]   next_active [8];
    logic [15:0]   tgt         [8];
    logic [16:0]   diff        [8];
    logic [16:0]   mag         [8];

    // Microsecond tick and end-of-frame detection
    always_comb begin
        tick     = (pre_cnt == PRE_LAST);
        boundary = tick && (us_cnt == FRAME_LAST);
    end

    // Per-channel clamp of the target, then limit the step toward it
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            tgt[i] = pulse_width_flat[16*i +: 16];
            if (tgt[i] < MIN_W) begin
                tgt[i] = MIN_W;
            end else if (tgt[i] > MAX_W) begin
                tgt[i] = MAX_W;
            end
            diff[i] = {1'b0, tgt[i]} - {1'b0, active[i]};
            mag[i]  = diff[i][16] ? (17'd0 - diff[i]) : diff[i];
            if ((SLEW_US == 0) || (mag[i] <= SLEW_D)) begin
                next_active[i] = tgt[i];
            end else if (diff[i][16]) begin
                next_active[i] = active[i] - SLEW_W;
            end else begin
                next_active[i] = active[i] + SLEW_W;
            end
        end
    end

    // Readback of the applied widths
    always_comb begin
        active_width_flat = '0;
        for (int i = 0; i < 8; i++) begin
            active_width_flat[16*i +: 16] = active[i];
        end
    end

    // Prescaler and frame counter; targets and enables latch only at the frame boundary
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            pre_cnt     <= '0;
            us_cnt      <= '0;
            en_active   <= '0;
            frame_start <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                active[i] <= NEUTRAL_W;
            end
        end else begin
            pre_cnt     <= tick ? '0 : pre_cnt + 1'b1;
            frame_start <= boundary;
            if (boundary) begin
                us_cnt    <= '0;
                en_active <= ch_enable;
                for (int i = 0; i < 8; i++) begin
                    active[i] <= next_active[i];
                end
            end else if (tick) begin
                us_cnt <= us_cnt + 15'd1;
            end
        end
    end

    // Registered outputs: high from frame start until the applied width elapses
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                pwm_out[i] <= en_active[i] & ({1'b0, us_cnt} < active[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_servo_frame_gen_8ch.sv
// tb/tb_pwm_servo_frame_gen_8ch.sv - self-checking bench for pwm_servo_frame_gen_8ch
module tb_pwm_servo_frame_gen_8ch;

    localparam int DIV   = 4;
    localparam int FRAME = 100;
    localparam int FCYC  = FRAME * DIV;

    logic         ACLK;
    logic         ARESET;
    logic [127:0] tgt_r;
    logic [7:0]   en_r;
    logic [7:0]   pwm0, pwm7;
    logic         fs0, fs7;
    logic [127:0] aw0, aw7;

    int checks = 0;
    int errors = 0;

    int m0 [8];
    int m7 [8];
    int w0 [8];
    int w7 [8];
    int c0 [8];
    int c7 [8];
    int men;

    typedef struct {
        logic [127:0] tgt;
        logic [7:0]   en;
        logic [127:0] exp0;
        logic [127:0] exp7;
    } vec_t;
    vec_t tbl [6];

    pwm_servo_frame_gen_8ch #(
        .CLK_FREQ_HZ(4000000), .FRAME_US(100), .MIN_US(10), .MAX_US(90),
        .NEUTRAL_US(50), .SLEW_US(0)
    ) dut0 (
        .ACLK(ACLK), .ARESET(ARESET), .pulse_width_flat(tgt_r), .ch_enable(en_r),
        .pwm_out(pwm0), .frame_start(fs0), .active_width_flat(aw0)
    );

    pwm_servo_frame_gen_8ch #(
        .CLK_FREQ_HZ(4000000), .FRAME_US(100), .MIN_US(10), .MAX_US(90),
        .NEUTRAL_US(50), .SLEW_US(7)
    ) dut7 (
        .ACLK(ACLK), .ARESET(ARESET), .pulse_width_flat(tgt_r), .ch_enable(en_r),
        .pwm_out(pwm7), .frame_start(fs7), .active_width_flat(aw7)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack8(input int a0, input int a1, input int a2, input int a3,
                                           input int a4, input int a5, input int a6, input int a7);
        logic [127:0] r;
        r = {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
        return r;
    endfunction

    function automatic int field(input logic [127:0] v, input int i);
        return int'(v[16*i +: 16]);
    endfunction

    // Reference: clamp into [10,90], then move at most 'slew' toward it (0 = jump)
    function automatic int ref_next(input int act, input int target, input int slew);
        int t;
        int d;
        t = (target < 10) ? 10 : ((target > 90) ? 90 : target);
        d = t - act;
        if (slew == 0 || (d <= slew && d >= -slew)) return t;
        return (d > 0) ? act + slew : act - slew;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m0[i] = 50;
            m7[i] = 50;
        end
        men = 0;
    endtask

    // Wait for the first frame_start after reset release; the whole first frame must be low
    task automatic wait_first(input string tag);
        int n;
        int hi;
        n  = 0;
        hi = 0;
        while (n < 1000) begin
            @(negedge ACLK);
            n++;
            if (fs0 && fs7) break;
            hi += ((pwm0 | pwm7) != 0) ? 1 : 0;
        end
        chk({tag, "_first_boundary"}, n, FCYC);
        chk({tag, "_first_frame_low"}, hi, 0);
    endtask

    // Called on the negedge that shows frame_start; measures one full frame and checks the model
    task automatic run_frame(input int apply_at, input logic [127:0] nt, input logic [7:0] ne);
        int early;
        for (int i = 0; i < 8; i++) begin
            m0[i] = ref_next(m0[i], field(tgt_r, i), 0);
            m7[i] = ref_next(m7[i], field(tgt_r, i), 7);
            w0[i] = field(aw0, i);
            w7[i] = field(aw7, i);
            c0[i] = 0;
            c7[i] = 0;
        end
        men   = int'(en_r);
        early = 0;
        for (int k = 1; k <= FCYC; k++) begin
            if (k == apply_at) begin
                tgt_r = nt;
                en_r  = ne;
            end
            @(negedge ACLK);
            for (int i = 0; i < 8; i++) begin
                c0[i] += int'(pwm0[i]);
                c7[i] += int'(pwm7[i]);
            end
            if (k < FCYC && (fs0 || fs7)) early++;
        end
        chk("frame_spacing", int'(fs0 & fs7) + early * 2, 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("model_w0_ch%0d", i), w0[i], m0[i]);
            chk($sformatf("model_w7_ch%0d", i), w7[i], m7[i]);
            chk($sformatf("model_c0_ch%0d", i), c0[i], men[i] ? m0[i] * DIV : 0);
            chk($sformatf("model_c7_ch%0d", i), c7[i], men[i] ? m7[i] * DIV : 0);
        end
    endtask

    initial begin
        logic [127:0] base;
        logic [127:0] nt;
        int sum;

        base = pack8(30, 5, 200, 80, 10, 90, 0, 65535);
        for (int v = 0; v < 6; v++) begin
            tbl[v].tgt  = base;
            tbl[v].exp0 = pack8(30, 10, 90, 80, 10, 90, 10, 90);
        end
        tbl[0].en = 8'h01; tbl[0].exp7 = pack8(43, 43, 57, 57, 43, 57, 43, 57);
        tbl[1].en = 8'h07; tbl[1].exp7 = pack8(36, 36, 64, 64, 36, 64, 36, 64);
        tbl[2].en = 8'hFF; tbl[2].exp7 = pack8(30, 29, 71, 71, 29, 71, 29, 71);
        tbl[3].en = 8'hFF; tbl[3].exp7 = pack8(30, 22, 78, 78, 22, 78, 22, 78);
        tbl[4].en = 8'hFF; tbl[4].exp7 = pack8(30, 15, 85, 80, 15, 85, 15, 85);
        tbl[5].en = 8'hFF; tbl[5].exp7 = pack8(30, 10, 90, 80, 10, 90, 10, 90);

        ARESET = 1'b1;
        tgt_r  = tbl[0].tgt;
        en_r   = tbl[0].en;
        model_reset();
        repeat (3) @(negedge ACLK);
        chk("reset_pwm", int'(pwm0 | pwm7), 0);
        chk("reset_frame_start", int'(fs0 | fs7), 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("reset_w0_ch%0d", i), field(aw0, i), 50);
            chk($sformatf("reset_w7_ch%0d", i), field(aw7, i), 50);
        end
        ARESET = 1'b0;
        wait_first("por");

        // Table phase: each vector is latched at its own boundary; the next one is written mid-frame
        for (int v = 0; v < 6; v++) begin
            if (v < 5) run_frame(200, tbl[v+1].tgt, tbl[v+1].en);
            else       run_frame(0, tgt_r, en_r);
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("tbl%0d_w0_ch%0d", v, i), w0[i], field(tbl[v].exp0, i));
                chk($sformatf("tbl%0d_w7_ch%0d", v, i), w7[i], field(tbl[v].exp7, i));
                chk($sformatf("tbl%0d_c0_ch%0d", v, i), c0[i], tbl[v].en[i] ? field(tbl[v].exp0, i) * DIV : 0);
                chk($sformatf("tbl%0d_c7_ch%0d", v, i), c7[i], tbl[v].en[i] ? field(tbl[v].exp7, i) * DIV : 0);
            end
        end

        // Mid-frame write at us_cnt=10: current pulse unchanged, next one uses the new width
        nt = base;
        nt[15:0] = 16'd60;
        run_frame(41, nt, 8'h01);
        chk("midwrite_cur_ch0", c0[0], 120);
        // Enable cleared mid-pulse: this pulse completes, next frame is low
        run_frame(101, nt, 8'h00);
        chk("midwrite_next_ch0", c0[0], 240);
        chk("midwrite_next_w0", w0[0], 60);
        run_frame(1, nt, 8'h01);
        sum = 0;
        for (int i = 0; i < 8; i++) sum += c0[i] + c7[i];
        chk("en_clear_next_low", sum, 0);

        // Reset in the middle of a live pulse
        repeat (100) @(negedge ACLK);
        chk("pre_reset_pulse_high", int'(pwm0[0]), 1);
        ARESET = 1'b1;
        #1;
        chk("async_reset_pwm", int'(pwm0 | pwm7), 0);
        chk("async_reset_fs", int'(fs0 | fs7), 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("async_reset_w0_ch%0d", i), field(aw0, i), 50);
            chk($sformatf("async_reset_w7_ch%0d", i), field(aw7, i), 50);
        end
        model_reset();
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        wait_first("midreset");

        // Randomized frames with writes landing anywhere inside the frame
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < 8; i++) begin
                nt[16*i +: 16] = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 120));
            end
            run_frame(int'($urandom_range(1, FCYC - 1)), nt, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
